// File: rtl/guess_history_display_if.sv
// Guess handshake between the message receiver and the history block.
// master: ready/msg/clear out, busy and status pulses in; slave: reverse.
interface guess_history_display_if;
   logic       ready;
   logic [7:0] msg;
   logic       clear;
   logic       busy;
   logic       accepted;
   logic       dup;
   logic       invalid;
   logic       full;

   modport master (
      output ready, msg, clear,
      input  busy, accepted, dup, invalid, full
   );

   modport slave (
      input  ready, msg, clear,
      output busy, accepted, dup, invalid, full
   );
endinterface

// File: rtl/guess_history_display.sv
// Guess history front end for two 16x2 LCD row buffers.
// Ports: clk, rst (sync high), bus (ready/msg/clear in, busy/status out),
// count (filled slots), row1 (last letter centred), row2 (history).
module guess_history_display #(
   parameter int         SLOTS = 10,
   parameter int         COLS  = 16,
   parameter logic [7:0] BLANK = 8'h5F,
   parameter bit         WRAP  = 1'b1
) (
   input  logic                       clk,
   input  logic                       rst,
   guess_history_display_if.slave     bus,
   output logic [$clog2(SLOTS+1)-1:0] count,
   output logic [8*COLS-1:0]          row1,
   output logic [8*COLS-1:0]          row2
);

   localparam int CW  = $clog2(SLOTS + 1);
   localparam int IW  = (SLOTS > 1) ? $clog2(SLOTS) : 1;
   localparam int MID = (COLS - 1) / 2;

   typedef enum logic [1:0] {
      IDLE,
      CHECK,
      CLEARING
   } state_t;

   state_t        state;
   state_t        nstate;

   logic [7:0]    slot [SLOTS];
   logic [CW-1:0] cnt;
   logic [7:0]    last;
   logic [7:0]    lat_ch;
   logic          lat_inv;
   logic [IW-1:0] idx;

   logic          acc_q;
   logic          dup_q;
   logic          inv_q;
   logic          ful_q;

   logic [7:0]    norm;
   logic          inv_in;
   logic          hit;
   logic          is_full;

   logic          do_latch;
   logic          do_acc;
   logic          do_dup;
   logic          do_inv;
   logic          do_ful;
   logic          start_clr;
   logic          clr_step;
   logic          clr_done;

   // Fold lowercase onto uppercase; anything outside the two
   // letter ranges is flagged and carried to CHECK as invalid.
   always_comb begin
      norm   = bus.msg;
      inv_in = 1'b1;
      if (bus.msg >= 8'h61 && bus.msg <= 8'h7A) begin
         norm   = bus.msg - 8'h20;
         inv_in = 1'b0;
      end else if (bus.msg >= 8'h41 && bus.msg <= 8'h5A) begin
         inv_in = 1'b0;
      end
   end

   // Only the filled part of the history takes part in the
   // duplicate search; stale slots beyond count never match.
   always_comb begin
      hit = 1'b0;
      for (int i = 0; i < SLOTS; i++) begin
         if ((CW'(i) < cnt) && (slot[i] == lat_ch)) begin
            hit = 1'b1;
         end
      end
   end

   assign is_full = (cnt == CW'(SLOTS));

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= nstate;
      end
   end

   always_comb begin
      nstate    = state;
      do_latch  = 1'b0;
      do_acc    = 1'b0;
      do_dup    = 1'b0;
      do_inv    = 1'b0;
      do_ful    = 1'b0;
      start_clr = 1'b0;
      clr_step  = 1'b0;
      clr_done  = 1'b0;
      unique case (state)
         IDLE: begin
            if (bus.clear) begin
               nstate    = CLEARING;
               start_clr = 1'b1;
            end else if (bus.ready) begin
               nstate   = CHECK;
               do_latch = 1'b1;
            end
         end
         CHECK: begin
            nstate = IDLE;
            priority case (1'b1)
               lat_inv:          do_inv = 1'b1;
               hit:              do_dup = 1'b1;
               (is_full && !WRAP): do_ful = 1'b1;
               default:          do_acc = 1'b1;
            endcase
         end
         CLEARING: begin
            clr_step = 1'b1;
            if (idx == IW'(SLOTS - 1)) begin
               clr_done = 1'b1;
               nstate   = IDLE;
            end
         end
         default: nstate = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < SLOTS; i++) begin
            slot[i] <= BLANK;
         end
         cnt     <= '0;
         last    <= 8'h20;
         lat_ch  <= 8'h20;
         lat_inv <= 1'b0;
         idx     <= '0;
         acc_q   <= 1'b0;
         dup_q   <= 1'b0;
         inv_q   <= 1'b0;
         ful_q   <= 1'b0;
      end else begin
         acc_q <= do_acc;
         dup_q <= do_dup;
         inv_q <= do_inv;
         ful_q <= do_ful;
         if (do_latch) begin
            lat_ch  <= norm;
            lat_inv <= inv_in;
         end
         if (start_clr) begin
            idx <= '0;
         end
         if (clr_step) begin
            slot[idx] <= BLANK;
            idx       <= idx + 1'b1;
         end
         if (clr_done) begin
            cnt  <= '0;
            last <= 8'h20;
         end
         if (do_acc) begin
            last <= lat_ch;
            if (!is_full) begin
               slot[cnt] <= lat_ch;
               cnt       <= cnt + 1'b1;
            end else begin
               // Full with wrap: oldest drops off the left end.
               for (int i = 0; i < SLOTS - 1; i++) begin
                  slot[i] <= slot[i+1];
               end
               slot[SLOTS-1] <= lat_ch;
            end
         end
      end
   end

   always_comb begin
      row1 = {COLS{8'h20}};
      row1[8*(COLS-1-MID) +: 8] = last;
      row2 = {COLS{8'h20}};
      for (int i = 0; i < SLOTS; i++) begin
         row2[8*(COLS-1-i) +: 8] = slot[i];
      end
   end

   assign bus.busy     = (state != IDLE);
   assign bus.accepted = acc_q;
   assign bus.dup      = dup_q;
   assign bus.invalid  = inv_q;
   assign bus.full     = ful_q;
   assign count        = cnt;

endmodule
